gray_counter: RTL

- Parametrised successor to the 4-bit combinational Gray-to-binary converter: a WIDTH-bit up/down counter that holds its state in binary.
- Presents registered Gray and binary views of the same count every cycle.
- Parallel load takes a Gray-coded value and converts it to binary internally.
- Used as the pointer/position source for Gray-coded buses, such as FIFO pointers and encoder positions.

---
 rtl/gray_counter.sv | 88 ++++++++
 1 files changed

// File: rtl/gray_counter.sv
// rtl/gray_counter.sv - WIDTH-bit binary up/down counter with registered Gray and binary views
// Optional build macro GRAY_COUNTER_SAT_EN selects saturating limits instead of modular wrap-around.
module gray_counter #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] load_gray,
  output logic [WIDTH-1:0] bin,
  output logic [WIDTH-1:0] gray,
  output logic             wrap
);

  localparam logic [WIDTH-1:0] ONE      = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] ZERO     = {WIDTH{1'b0}};

  // Prefix XOR from the MSB down.
  function automatic logic [WIDTH-1:0] g2b(input logic [WIDTH-1:0] g);
    logic [WIDTH-1:0] b;
    b[WIDTH-1] = g[WIDTH-1];
    for (int i = WIDTH - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  function automatic logic [WIDTH-1:0] b2g(input logic [WIDTH-1:0] b);
    return b ^ (b >> 1);
  endfunction

  logic [WIDTH-1:0] next_bin;
  logic             next_wrap;
  logic             at_max;
  logic             at_min;

  assign at_max = (bin == ALL_ONES);
  assign at_min = (bin == ZERO);

  always_comb begin
    next_bin  = bin;
    next_wrap = 1'b0;
    if (load) begin
      next_bin = g2b(load_gray);
    end else if (en) begin
      if (up) begin
`ifdef GRAY_COUNTER_SAT_EN
        if (at_max) begin
          next_wrap = 1'b1;
        end else begin
          next_bin = bin + ONE;
        end
`else
        next_bin  = bin + ONE;
        next_wrap = at_max;
`endif
      end else begin
`ifdef GRAY_COUNTER_SAT_EN
        if (at_min) begin
          next_wrap = 1'b1;
        end else begin
          next_bin = bin - ONE;
        end
`else
        next_bin  = bin - ONE;
        next_wrap = at_min;
`endif
      end
    end
  end

  // Gray comes from next_bin so both views change on the same edge without skew.
  always_ff @(posedge clk) begin
    if (reset) begin
      bin  <= ZERO;
      gray <= ZERO;
      wrap <= 1'b0;
    end else begin
      bin  <= next_bin;
      gray <= b2g(next_bin);
      wrap <= next_wrap;
    end
  end

endmodule
